// File: rtl/vga_text_refresher_pkg.sv
// Shared definitions for the VGA debug text-buffer refresher.
//   - FSM state encoding for the sweep scheduler
//   - text buffer geometry (rows, write-address width)
//   - ASCII base codes used by the hex renderer
package vga_dbg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SNAP = 2'd1,
    ST_EMIT = 2'd2
  } state_t;

  localparam int TEXT_ROWS = 30;
  localparam int ADDR_W    = 12;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_A    = 8'h41;

endpackage

// File: rtl/vga_text_refresher_if.sv
// Text-buffer write port shared between a host writer and the refresher.
//   host_req/host_addr/host_data : host write request (host -> refresher)
//   host_ack                     : host write issued this cycle
//   wen/w_addr/w_data            : buffer write port (refresher -> buffer)
// slave  : the refresher side
// master : the host / buffer side
interface vga_text_refresher_if;
  import vga_dbg_pkg::*;

  logic              host_req;
  logic [ADDR_W-1:0] host_addr;
  logic [7:0]        host_data;
  logic              host_ack;
  logic              wen;
  logic [ADDR_W-1:0] w_addr;
  logic [7:0]        w_data;

  modport slave (
    input  host_req, host_addr, host_data,
    output host_ack, wen, w_addr, w_data
  );

  modport master (
    output host_req, host_addr, host_data,
    input  host_ack, wen, w_addr, w_data
  );

endinterface

// File: rtl/vga_text_refresher_hex_nibble_to_ascii.sv
// Combinational 4-bit to uppercase hex ASCII encoder.
//   i_nibble : value 0..15
//   o_ascii  : '0'..'9' or 'A'..'F'
module hex_nibble_to_ascii
  import vga_dbg_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [7:0] o_ascii
);

  always_comb begin
    if (i_nibble < 4'd10) begin
      o_ascii = ASCII_ZERO + {4'h0, i_nibble};
    end else begin
      o_ascii = ASCII_A + ({4'h0, i_nibble} - 8'd10);
    end
  end

endmodule

// File: rtl/vga_text_refresher.sv
// Write-port scheduler for the 80x30 VGA debug text buffer.
// Periodically (or on request) snapshots NUM_SLOTS 32-bit debug values and
// renders each as 8 uppercase hex characters at fixed buffer positions. The
// host writer shares the single write port and always wins.
//   clk, rst    : clock, synchronous active-high reset
//   debug_data  : slot i at bits [32i+31:32i]
//   start       : pulse requesting an immediate sweep
//   bus         : host request/ack and buffer write port (slave side)
//   busy        : sweep in progress (SNAP through last character)
//   frame_done  : one-cycle pulse after the last character of a sweep
module vga_text_refresher
  import vga_dbg_pkg::*;
#(
  parameter int NUM_SLOTS      = 16,
  parameter int TEXT_COLS      = 80,
  parameter int FIRST_ROW      = 2,
  parameter int LABEL_W        = 8,
  parameter int REFRESH_CYCLES = 1000000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_SLOTS*32-1:0] debug_data,
  input  logic                   start,
  vga_text_refresher_if.slave    bus,
  output logic                   busy,
  output logic                   frame_done
);

  localparam int SLOT_W   = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int CNT_W    = $clog2(REFRESH_CYCLES);
  localparam int HALF_ROW = 40;

  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(REFRESH_CYCLES - 1);

  state_t                  r_state;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_pending;
  logic [SLOT_W-1:0]       r_slot;
  logic [2:0]              r_nib;
  logic                    r_busy;
  logic                    r_frame_done;
  logic [NUM_SLOTS*32-1:0] r_shadow;

  logic              w_trigger;
  logic              w_sweep_wr;
  logic [3:0]        w_nibble;
  logic [7:0]        w_char;
  logic [ADDR_W-1:0] w_row;
  logic [ADDR_W-1:0] w_col;
  logic [ADDR_W-1:0] w_sweep_addr;

  assign w_trigger  = (r_cnt == CNT_LAST) || start || r_pending;
  assign w_sweep_wr = (r_state == ST_EMIT) && !bus.host_req;

  // slot*32 + nib*4 is just the concatenation of the two indices
  assign w_nibble = r_shadow[{r_slot, r_nib, 2'b00} +: 4];

  // Two slots per row; the most significant nibble lands in the leftmost
  // column of the field, hence 7-nib.
  assign w_row        = ADDR_W'(FIRST_ROW) + ADDR_W'(r_slot >> 1);
  assign w_col        = (r_slot[0] ? ADDR_W'(HALF_ROW) : '0) + ADDR_W'(LABEL_W)
                        + ADDR_W'(3'd7 - r_nib);
  assign w_sweep_addr = w_row * ADDR_W'(TEXT_COLS) + w_col;

  hex_nibble_to_ascii u_hex (
    .i_nibble (w_nibble),
    .o_ascii  (w_char)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_pending    <= 1'b0;
      r_slot       <= '0;
      r_nib        <= 3'd7;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_trigger) begin
            r_cnt     <= '0;
            r_pending <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= ST_SNAP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_SNAP: begin
          if (start) r_pending <= 1'b1;
          r_slot  <= '0;
          r_nib   <= 3'd7;
          r_state <= ST_EMIT;
        end
        ST_EMIT: begin
          // Requests arriving mid-sweep collapse into one follow-up sweep.
          if (start) r_pending <= 1'b1;
          // A host write steals the port: the sweep position holds.
          if (!bus.host_req) begin
            if (r_nib == 3'd0) begin
              r_nib <= 3'd7;
              if (r_slot == LAST_SLOT) begin
                r_busy       <= 1'b0;
                r_frame_done <= 1'b1;
                r_state      <= ST_IDLE;
              end else begin
                r_slot <= r_slot + 1'b1;
              end
            end else begin
              r_nib <= r_nib - 3'd1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Snapshot register carries data only, so it is not reset.
  always_ff @(posedge clk) begin
    if (r_state == ST_SNAP) r_shadow <= debug_data;
  end

  // Host has combinational priority on the shared write port.
  always_comb begin
    bus.host_ack = bus.host_req;
    bus.wen      = bus.host_req | w_sweep_wr;
    bus.w_addr   = '0;
    bus.w_data   = '0;
    if (bus.host_req) begin
      bus.w_addr = bus.host_addr;
      bus.w_data = bus.host_data;
    end else if (w_sweep_wr) begin
      bus.w_addr = w_sweep_addr;
      bus.w_data = w_char;
    end
  end

  assign busy       = r_busy;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_vga_text_refresher.sv
// Directed testbench for vga_text_refresher.
// dut_a: slow auto-refresh, driven by start pulses and host writes.
// dut_b: REFRESH_CYCLES=10, free-running periodic sweeps.
module tb_vga_text_refresher;

  logic           clk = 1'b0;
  logic           rst;
  logic           start_a;
  logic           start_b;
  logic [511:0]   dbg;
  logic           busy_a, fd_a, busy_b, fd_b;
  int             vecs = 0;
  int             errs = 0;

  vga_text_refresher_if bus_a ();
  vga_text_refresher_if bus_b ();

  vga_text_refresher #(.NUM_SLOTS(16), .REFRESH_CYCLES(100000)) dut_a (
    .clk(clk), .rst(rst), .debug_data(dbg), .start(start_a),
    .bus(bus_a.slave), .busy(busy_a), .frame_done(fd_a));

  vga_text_refresher #(.NUM_SLOTS(16), .REFRESH_CYCLES(10)) dut_b (
    .clk(clk), .rst(rst), .debug_data(dbg), .start(start_b),
    .bus(bus_b.slave), .busy(busy_b), .frame_done(fd_b));

  always #5 clk = ~clk;

  function automatic logic [7:0] hexc(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  function automatic logic [11:0] exp_addr(input int s, input int n);
    return 12'((2 + s / 2) * 80 + (s % 2) * 40 + 8 + 7 - n);
  endfunction

  task automatic nc();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; dbg = '0;
    bus_a.host_req = 1'b0; bus_a.host_addr = '0; bus_a.host_data = '0;
    bus_b.host_req = 1'b0; bus_b.host_addr = '0; bus_b.host_data = '0;
    repeat (3) nc();
    smp();
    vecs++; if (bus_a.wen !== 1'b0) begin errs++; $display("FAIL reset_wen got %0b want 0", bus_a.wen); end
    vecs++; if (busy_a !== 1'b0) begin errs++; $display("FAIL reset_busy got %0b want 0", busy_a); end
    vecs++; if (fd_a !== 1'b0) begin errs++; $display("FAIL reset_frame_done got %0b want 0", fd_a); end
    vecs++; if (bus_a.host_ack !== 1'b0) begin errs++; $display("FAIL reset_ack got %0b want 0", bus_a.host_ack); end
    vecs++; if ({bus_a.w_addr, bus_a.w_data} !== 20'h0) begin errs++; $display("FAIL reset_addr_data got %h/%h want 0/0", bus_a.w_addr, bus_a.w_data); end
    nc(); rst = 1'b0;
    smp();
    vecs++; if (busy_a !== 1'b0) begin errs++; $display("FAIL idle_busy got %0b want 0", busy_a); end
    nc(); bus_a.host_req = 1'b1; bus_a.host_addr = 12'h123; bus_a.host_data = 8'h5A;
    smp();
    vecs++; if ({bus_a.wen, bus_a.host_ack, bus_a.w_addr, bus_a.w_data} !== {2'b11, 12'h123, 8'h5A}) begin
      errs++; $display("FAIL idle_host_write got wen=%0b ack=%0b %h/%h want 1 1 123/5a", bus_a.wen, bus_a.host_ack, bus_a.w_addr, bus_a.w_data); end
    nc(); bus_a.host_req = 1'b0;
    smp();
    vecs++; if ({bus_a.wen, bus_a.host_ack} !== 2'b00) begin errs++; $display("FAIL idle_no_write got wen=%0b ack=%0b want 0 0", bus_a.wen, bus_a.host_ack); end
  endtask

  task automatic test_sweep_basic();
    logic [7:0]  d0 [0:7];
    logic [11:0] wa;
    logic [7:0]  wd;
    int nbusy, nfd, s, n;
    d0 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h41, 8'h42, 8'h43, 8'h44};
    dbg = '0;
    dbg[31:0]   = 32'h1234ABCD;
    dbg[63:32]  = 32'hDEADBEEF;
    dbg[127:96] = 32'h0000000F;
    nbusy = 0; nfd = 0;
    nc(); start_a = 1'b1;
    smp();
    vecs++; if (busy_a !== 1'b0) begin errs++; $display("FAIL start_cycle_busy got %0b want 0", busy_a); end
    nc(); start_a = 1'b0;
    smp();
    if (busy_a) nbusy++;
    vecs++; if ({busy_a, bus_a.wen} !== 2'b10) begin errs++; $display("FAIL snap_cycle got busy=%0b wen=%0b want 1 0", busy_a, bus_a.wen); end
    for (int k = 0; k < 128; k++) begin
      nc(); smp();
      if (busy_a) nbusy++;
      if (fd_a) nfd++;
      s = k / 8; n = 7 - (k % 8);
      if (k < 8) begin
        wa = 12'(168 + k); wd = d0[k];
      end else if (k >= 24 && k < 32) begin
        wa = 12'(288 + k - 24); wd = (k == 31) ? 8'h46 : 8'h30;
      end else begin
        wa = exp_addr(s, n); wd = hexc(dbg[s*32 + n*4 +: 4]);
      end
      vecs++; if ({bus_a.wen, bus_a.w_addr, bus_a.w_data} !== {1'b1, wa, wd}) begin
        errs++; $display("FAIL sweep_char%0d got wen=%0b %0d/%h want 1 %0d/%h", k, bus_a.wen, bus_a.w_addr, bus_a.w_data, wa, wd); end
    end
    nc(); smp();
    if (busy_a) nbusy++;
    if (fd_a) nfd++;
    vecs++; if ({fd_a, bus_a.wen, busy_a} !== 3'b100) begin
      errs++; $display("FAIL sweep_end got fd=%0b wen=%0b busy=%0b want 1 0 0", fd_a, bus_a.wen, busy_a); end
    repeat (3) begin nc(); smp(); if (busy_a) nbusy++; if (fd_a) nfd++; end
    vecs++; if (nbusy !== 129) begin errs++; $display("FAIL sweep_busy_len got %0d want 129", nbusy); end
    vecs++; if (nfd !== 1) begin errs++; $display("FAIL sweep_fd_count got %0d want 1", nfd); end
  endtask

  task automatic test_snapshot();
    logic [511:0] snapv;
    int s, n, bad;
    for (int i = 0; i < 16; i++) dbg[i*32 +: 32] = 32'h89ABCDEF + i * 32'h10203040;
    snapv = dbg;
    bad = 0;
    nc(); start_a = 1'b1;
    nc(); start_a = 1'b0;
    for (int k = 0; k < 128; k++) begin
      nc();
      if (k == 0) dbg = '1;
      smp();
      s = k / 8; n = 7 - (k % 8);
      vecs++; if ({bus_a.wen, bus_a.w_addr, bus_a.w_data} !== {1'b1, exp_addr(s, n), hexc(snapv[s*32 + n*4 +: 4])}) begin
        errs++; $display("FAIL snapshot_char%0d got wen=%0b %0d/%h want 1 %0d/%h", k, bus_a.wen, bus_a.w_addr, bus_a.w_data, exp_addr(s, n), hexc(snapv[s*32 + n*4 +: 4])); end
    end
    repeat (3) nc();
  endtask

  task automatic test_host_stall();
    int nbusy;
    logic found;
    dbg = '0;
    dbg[31:0] = 32'h1234ABCD;
    nbusy = 0;
    nc(); start_a = 1'b1;
    nc(); start_a = 1'b0;
    smp(); if (busy_a) nbusy++;
    nc(); smp(); if (busy_a) nbusy++;
    vecs++; if ({bus_a.w_addr, bus_a.w_data} !== {12'd168, 8'h31}) begin errs++; $display("FAIL stall_pre0 got %0d/%h want 168/31", bus_a.w_addr, bus_a.w_data); end
    nc(); smp(); if (busy_a) nbusy++;
    vecs++; if ({bus_a.w_addr, bus_a.w_data} !== {12'd169, 8'h32}) begin errs++; $display("FAIL stall_pre1 got %0d/%h want 169/32", bus_a.w_addr, bus_a.w_data); end
    for (int j = 0; j < 3; j++) begin
      nc();
      bus_a.host_req = 1'b1; bus_a.host_addr = 12'(12'h700 + j); bus_a.host_data = 8'(8'h61 + j);
      smp(); if (busy_a) nbusy++;
      vecs++; if ({bus_a.wen, bus_a.host_ack, busy_a, bus_a.w_addr, bus_a.w_data} !== {3'b111, 12'(12'h700 + j), 8'(8'h61 + j)}) begin
        errs++; $display("FAIL stall_host%0d got wen=%0b ack=%0b busy=%0b %h/%h want 1 1 1 %h/%h", j, bus_a.wen, bus_a.host_ack, busy_a, bus_a.w_addr, bus_a.w_data, 12'(12'h700 + j), 8'(8'h61 + j)); end
    end
    nc(); bus_a.host_req = 1'b0;
    smp(); if (busy_a) nbusy++;
    vecs++; if ({bus_a.wen, bus_a.host_ack, bus_a.w_addr, bus_a.w_data} !== {2'b10, 12'd170, 8'h33}) begin
      errs++; $display("FAIL stall_resume got wen=%0b ack=%0b %0d/%h want 1 0 170/33", bus_a.wen, bus_a.host_ack, bus_a.w_addr, bus_a.w_data); end
    found = 1'b0;
    for (int t = 0; t < 200 && !found; t++) begin
      nc(); smp();
      if (busy_a) nbusy++;
      if (fd_a) found = 1'b1;
    end
    vecs++; if (found !== 1'b1) begin errs++; $display("FAIL stall_done got no frame_done want frame_done within 200 cycles"); end
    vecs++; if (nbusy !== 132) begin errs++; $display("FAIL stall_busy_len got %0d want 132", nbusy); end
    repeat (2) nc();
  endtask

  task automatic test_back_to_back();
    int rises, nfd, f1, f2;
    logic prev, busy_after;
    rises = 0; nfd = 0; f1 = -1; f2 = -1; prev = 1'b0; busy_after = 1'b0;
    nc(); start_a = 1'b1;
    for (int idx = 1; idx < 400; idx++) begin
      nc();
      start_a = (idx == 5 || idx == 20);
      smp();
      if (busy_a && !prev) rises++;
      prev = busy_a;
      if (f1 >= 0 && idx == f1 + 1) busy_after = busy_a;
      if (fd_a) begin
        nfd++;
        if (f1 < 0) f1 = idx; else f2 = idx;
      end
    end
    vecs++; if (rises !== 2) begin errs++; $display("FAIL b2b_sweeps got %0d want 2", rises); end
    vecs++; if (nfd !== 2) begin errs++; $display("FAIL b2b_frame_done got %0d want 2", nfd); end
    vecs++; if (f1 !== 130) begin errs++; $display("FAIL b2b_first_done got %0d want 130", f1); end
    vecs++; if (f2 !== 260) begin errs++; $display("FAIL b2b_second_done got %0d want 260", f2); end
    vecs++; if (busy_after !== 1'b1) begin errs++; $display("FAIL b2b_immediate_restart got %0b want 1", busy_after); end
  endtask

  task automatic test_reset_midsweep();
    int stray;
    stray = 0;
    nc(); start_a = 1'b1;
    for (int idx = 1; idx <= 42; idx++) begin
      nc();
      start_a = 1'b0;
      if (idx == 42) rst = 1'b1;
    end
    smp();
    vecs++; if ({bus_a.wen, bus_a.w_addr} !== {1'b1, 12'd368}) begin errs++; $display("FAIL rstmid_slot5 got wen=%0b %0d want 1 368", bus_a.wen, bus_a.w_addr); end
    nc(); smp();
    vecs++; if ({bus_a.wen, busy_a} !== 2'b00) begin errs++; $display("FAIL rstmid_after got wen=%0b busy=%0b want 0 0", bus_a.wen, busy_a); end
    nc(); rst = 1'b0;
    for (int t = 0; t < 30; t++) begin
      smp();
      if (bus_a.wen || busy_a || fd_a) stray++;
      nc();
    end
    vecs++; if (stray !== 0) begin errs++; $display("FAIL rstmid_quiet got %0d active cycles want 0", stray); end
  endtask

  task automatic test_periodic();
    int s1, s2, f1;
    logic prev, addr_ok;
    s1 = -1; s2 = -1; f1 = -1; prev = 1'b0; addr_ok = 1'b0;
    rst = 1'b1;
    repeat (2) nc();
    nc(); rst = 1'b0;
    for (int idx = 0; idx <= 170; idx++) begin
      if (idx > 0) nc();
      smp();
      if (busy_b && !prev) begin
        if (s1 < 0) s1 = idx; else if (s2 < 0) s2 = idx;
      end
      prev = busy_b;
      if (fd_b && f1 < 0) f1 = idx;
      if (idx == 11) addr_ok = bus_b.wen && (bus_b.w_addr == 12'd168);
    end
    vecs++; if (s1 !== 10) begin errs++; $display("FAIL periodic_first_snap got %0d want 10", s1); end
    vecs++; if (f1 !== 139) begin errs++; $display("FAIL periodic_done got %0d want 139", f1); end
    vecs++; if (s2 !== 149) begin errs++; $display("FAIL periodic_second_snap got %0d want 149", s2); end
    vecs++; if (addr_ok !== 1'b1) begin errs++; $display("FAIL periodic_first_write got %0b want 1", addr_ok); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sweep_basic();
    test_snapshot();
    test_host_stall();
    test_back_to_back();
    test_reset_midsweep();
    test_periodic();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
